axi_slave_bridge: RTL and testbench
===================================

Name: axi_slave_bridge

Overview:
Parametrised AXI slave front end; successor of the single-port slave interface. Independent write and read FSMs, each holding one outstanding burst, convert AXI bursts (FIXED/INCR/WRAP, len 0..255) into single-beat accesses on one shared "other" request/ready port. A round-robin arbiter shares that port between the two directions. Error and illegal-burst responses are generated per burst.

Parameters:
AXI_ADDR_WIDTH, 32, address width of AXI and other port
AXI_DATA_WIDTH, 32, data width; power of two, 8..1024
AXI_ID_WIDTH, 4, AWID/ARID/BID/RID width
ADDR_LO, 0, lowest decoded address (used only with AXI_SLV_DECODE_EN)
ADDR_HI, 32'hFFFF_FFFF, highest decoded address (used only with AXI_SLV_DECODE_EN)
Derived localparams: AXI_WSTRB_WIDTH = AXI_DATA_WIDTH/8; MAX_SIZE = log2(AXI_WSTRB_WIDTH).

Ports:
axi_clk_in  in  1  clock, all logic on rising edge
axi_rstn_in  in  1  reset, asynchronous, active-low
axi_aw{addr,burst,cache,id,len,prot,size,valid}_in, axi_awready_out  write address channel, standard AXI widths
axi_wdata_in, axi_wstrb_in, axi_wlast_in, axi_wvalid_in, axi_wready_out  write data channel
axi_bid_out, axi_bresp_out(2), axi_bvalid_out, axi_bready_in  write response channel
axi_ar{addr,burst,cache,id,len,prot,size,valid}_in, axi_arready_out  read address channel
axi_rid_out, axi_rdata_out, axi_rresp_out(2), axi_rlast_out, axi_rvalid_out, axi_rready_in  read data channel
other_sel_out  out  1  access request, held until accepted
other_write_out  out  1  1 = write, 0 = read
other_addr_out  out  AXI_ADDR_WIDTH  beat address
other_size_out  out  3  beat size
other_cache_out  out  4  AxCACHE of the burst
other_prot_out  out  3  AxPROT of the burst
other_strb_out / other_wdata_out  out  WSTRB/DATA  write strobe and data
other_rdata_in  in  AXI_DATA_WIDTH  read data, valid with ready
other_ready_in  in  1  access completes on the edge where sel && ready
other_error_in  in  1  sampled with ready; 1 = slave error

Behaviour:
- Reset: every output is 0 except axi_awready_out = axi_arready_out = 1. FSMs go to IDLE; arbiter priority goes to write. A reset mid-burst discards the burst with no response.
- Write FSM: W_IDLE -> W_DATA -> W_ACC -> (W_DATA | W_RESP) -> W_IDLE.
  - W_IDLE: awready = 1. On awvalid, latch all AW fields plus beat counter = awlen and err = 0, then drop awready.
  - W_DATA: wready = 1. On wvalid, latch wdata/wstrb, drop wready, go to W_ACC.
  - W_ACC: request the other port. On grant && ready, set err |= other_error_in.
  - Last beat (counter 0) -> W_RESP, otherwise decrement the counter and step the address.
  - W_RESP: bvalid = 1, bid = latched awid, bresp = err ? SLVERR(2) : OKAY(0). Held until bready, then W_IDLE.
  - A wlast value that disagrees with counter == 0 sets err. The beat count follows awlen; wlast does not end the burst.
- Read FSM: R_IDLE -> R_ACC -> R_DATA -> (R_ACC | R_IDLE).
  - R_IDLE: arready = 1; latch AR fields on arvalid.
  - R_ACC: on grant && ready, capture rdata; rresp = other_error_in ? SLVERR : OKAY.
  - R_DATA: rvalid = 1, rlast = (counter == 0), rid = latched arid. rdata/rresp/rlast are stable until rready.
- Arbiter and other port:
  - Only one direction owns the other port at a time.
  - If both request together, the non-priority-holder loses; priority toggles after each completed access.
  - sel/addr/size/write/data are stable while sel = 1 and ready = 0.
  - Minimum spacing is one access per 2 cycles per direction.
  - sel is deasserted the cycle after acceptance.
- Address step, computed at AXI_ADDR_WIDTH with wrap modulo 2^AXI_ADDR_WIDTH:
  - FIXED: unchanged.
  - INCR: addr + (1 << size).
  - WRAP: with B = (len+1) << size, next = (addr & ~(B-1)) | ((addr + (1<<size)) & (B-1)).
- Illegal bursts get no other-port access for any beat; the FSM still sequences every beat and the response is SLVERR. Illegal means any of:
  - burst == 3;
  - size > MAX_SIZE;
  - WRAP with len not in {1,3,7,15}.
- Simultaneous AW and AR acceptance is allowed; the two FSMs are fully independent apart from the arbiter.

Optional Feature:
AXI_SLV_DECODE_EN:
- Defined: a burst whose start address lies outside [ADDR_LO, ADDR_HI] makes no other-port accesses and returns DECERR(3) on B, or on every R beat with rdata = 0.
- Undefined: no decode check; the ADDR_LO/ADDR_HI parameters are ignored.

Decomposition:
- Package axi_pkg holds:
  - burst encodings FIXED/INCR/WRAP/RESERVED;
  - response encodings OKAY/EXOKAY/SLVERR/DECERR;
  - write and read state encodings;
  - function axi_next_addr(addr, size, len, burst).
- One sub-module, axi_burst_addr_gen: start/step inputs, current-address output, legality flag. It is instantiated once per direction.

Test Plan:
- INCR write: awaddr 0x100, len 3, size 2, data 0xA0..A3 -> other writes at 0x100/104/108/10C; bresp 0, bid equals awid.
- WRAP read: araddr 0x38, len 3, size 2 -> accesses 0x38, 0x3C, 0x30, 0x34; rlast only on the 4th beat; rready held low 3 cycles mid-burst keeps rdata stable.
- Concurrent 2-beat write and 2-beat read, other_ready_in always 1 -> accesses alternate W, R, W, R starting with W.
- other_error_in = 1 on beat 2 of a 4-beat write -> all 4 beats issued, bresp = 2; on a read, only beat 2 has rresp = 2.
- Illegal bursts: burst = 3 (len 1), and WRAP len 2 -> zero other_sel_out pulses; SLVERR returned on every beat; FSM returns to IDLE.
- axi_rstn_in asserted mid-burst during W_ACC -> all outputs take reset values asynchronously; a new AW after reset completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared encodings and the burst address-step helper for the AXI slave bridge.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_ACC  = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ACC  = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    // Helper works at 64 bits; callers truncate, which keeps the wrap modulo their width.
    localparam int unsigned NEXT_ADDR_W = 64;

    // Address of the following beat for FIXED/INCR/WRAP bursts.
    function automatic logic [NEXT_ADDR_W-1:0] axi_next_addr(
        input logic [NEXT_ADDR_W-1:0] addr,
        input logic [2:0]             size,
        input logic [7:0]             len,
        input logic [1:0]             burst
    );
        logic [NEXT_ADDR_W-1:0] incr;
        logic [NEXT_ADDR_W-1:0] bmask;
        logic [NEXT_ADDR_W-1:0] nxt;
        incr  = NEXT_ADDR_W'(1) << size;
        bmask = ((NEXT_ADDR_W'(len) + NEXT_ADDR_W'(1)) << size) - NEXT_ADDR_W'(1);
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_WRAP:  nxt = (addr & ~bmask) | ((addr + incr) & bmask);
            default:     nxt = addr + incr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-direction burst tracker: latches burst fields, steps the beat address,
// flags illegal bursts and (with AXI_SLV_DECODE_EN) out-of-range start addresses.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int unsigned               ADDR_W   = 32,
    parameter int unsigned               MAX_SIZE = 2,
    parameter logic [ADDR_W-1:0]         ADDR_LO  = '0,
    parameter logic [ADDR_W-1:0]         ADDR_HI  = '1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [7:0]        i_len,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_addr,
    output logic [2:0]        o_size,
    output logic              o_legal,
    output logic              o_decerr
);

`ifdef AXI_SLV_DECODE_EN
    localparam logic DECODE_EN = 1'b1;
`else
    localparam logic DECODE_EN = 1'b0;
`endif

    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_size;
    logic [7:0]        r_len;
    logic [1:0]        r_burst;
    logic              r_legal;
    logic              r_decerr;
    logic              w_legal;
    logic [ADDR_W:0]   w_lo_diff;
    logic [ADDR_W:0]   w_hi_diff;
    logic              w_out_of_range;
    logic [ADDR_W-1:0] w_next;

    // Burst legality and address-range decode of the incoming request.
    always_comb begin
        w_legal = (i_burst != BURST_RSVD) && (i_size <= 3'(MAX_SIZE));
        if (i_burst == BURST_WRAP &&
            !(i_len == 8'd1 || i_len == 8'd3 || i_len == 8'd7 || i_len == 8'd15))
            w_legal = 1'b0;
        w_lo_diff      = {1'b0, i_addr} - {1'b0, ADDR_LO};
        w_hi_diff      = {1'b0, ADDR_HI} - {1'b0, i_addr};
        w_out_of_range = w_lo_diff[ADDR_W] | w_hi_diff[ADDR_W];
        w_next = ADDR_W'(axi_next_addr(NEXT_ADDR_W'(r_addr), r_size, r_len, r_burst));
    end

    // Burst context register; start wins over step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr   <= '0;
            r_size   <= '0;
            r_len    <= '0;
            r_burst  <= '0;
            r_legal  <= 1'b0;
            r_decerr <= 1'b0;
        end else if (i_start) begin
            r_addr   <= i_addr;
            r_size   <= i_size;
            r_len    <= i_len;
            r_burst  <= i_burst;
            r_legal  <= w_legal;
            r_decerr <= DECODE_EN & w_out_of_range;
        end else if (i_step) begin
            r_addr   <= w_next;
        end
    end

    assign o_addr   = r_addr;
    assign o_size   = r_size;
    assign o_legal  = r_legal;
    assign o_decerr = r_decerr;

endmodule

// File: rtl/axi_slave_bridge.sv
// AXI slave front end: independent write/read burst FSMs sharing one single-beat
// "other" port through a round-robin arbiter. Optional macro AXI_SLV_DECODE_EN
// enables the ADDR_LO..ADDR_HI start-address decode (DECERR outside the window).
module axi_slave_bridge
    import axi_pkg::*;
#(
    parameter int unsigned                 AXI_ADDR_WIDTH = 32,
    parameter int unsigned                 AXI_DATA_WIDTH = 32,
    parameter int unsigned                 AXI_ID_WIDTH   = 4,
    parameter logic [AXI_ADDR_WIDTH-1:0]   ADDR_LO        = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0]   ADDR_HI        = AXI_ADDR_WIDTH'(32'hFFFF_FFFF)
) (
    input  logic                          axi_clk_in,
    input  logic                          axi_rstn_in,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_awaddr_in,
    input  logic [1:0]                    axi_awburst_in,
    input  logic [3:0]                    axi_awcache_in,
    input  logic [AXI_ID_WIDTH-1:0]       axi_awid_in,
    input  logic [7:0]                    axi_awlen_in,
    input  logic [2:0]                    axi_awprot_in,
    input  logic [2:0]                    axi_awsize_in,
    input  logic                          axi_awvalid_in,
    output logic                          axi_awready_out,
    input  logic [AXI_DATA_WIDTH-1:0]     axi_wdata_in,
    input  logic [AXI_DATA_WIDTH/8-1:0]   axi_wstrb_in,
    input  logic                          axi_wlast_in,
    input  logic                          axi_wvalid_in,
    output logic                          axi_wready_out,
    output logic [AXI_ID_WIDTH-1:0]       axi_bid_out,
    output logic [1:0]                    axi_bresp_out,
    output logic                          axi_bvalid_out,
    input  logic                          axi_bready_in,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_araddr_in,
    input  logic [1:0]                    axi_arburst_in,
    input  logic [3:0]                    axi_arcache_in,
    input  logic [AXI_ID_WIDTH-1:0]       axi_arid_in,
    input  logic [7:0]                    axi_arlen_in,
    input  logic [2:0]                    axi_arprot_in,
    input  logic [2:0]                    axi_arsize_in,
    input  logic                          axi_arvalid_in,
    output logic                          axi_arready_out,
    output logic [AXI_ID_WIDTH-1:0]       axi_rid_out,
    output logic [AXI_DATA_WIDTH-1:0]     axi_rdata_out,
    output logic [1:0]                    axi_rresp_out,
    output logic                          axi_rlast_out,
    output logic                          axi_rvalid_out,
    input  logic                          axi_rready_in,
    output logic                          other_sel_out,
    output logic                          other_write_out,
    output logic [AXI_ADDR_WIDTH-1:0]     other_addr_out,
    output logic [2:0]                    other_size_out,
    output logic [3:0]                    other_cache_out,
    output logic [2:0]                    other_prot_out,
    output logic [AXI_DATA_WIDTH/8-1:0]   other_strb_out,
    output logic [AXI_DATA_WIDTH-1:0]     other_wdata_out,
    input  logic [AXI_DATA_WIDTH-1:0]     other_rdata_in,
    input  logic                          other_ready_in,
    input  logic                          other_error_in
);

    localparam int unsigned AXI_WSTRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int unsigned MAX_SIZE        = $clog2(AXI_WSTRB_WIDTH);

    // Write side
    logic [1:0]                 r_w_state, w_w_next;
    logic [AXI_ID_WIDTH-1:0]    r_aw_id;
    logic [3:0]                 r_aw_cache;
    logic [2:0]                 r_aw_prot;
    logic [7:0]                 r_w_cnt;
    logic                       r_w_err;
    logic [AXI_DATA_WIDTH-1:0]  r_wdata;
    logic [AXI_WSTRB_WIDTH-1:0] r_wstrb;
    logic                       r_awready, r_wready, r_bvalid;
    logic [1:0]                 r_bresp;
    logic [AXI_ADDR_WIDTH-1:0]  w_w_addr;
    logic [2:0]                 w_w_size;
    logic                       w_w_legal, w_w_decerr;
    logic                       w_aw_hs, w_w_hs, w_w_skip, w_w_req, w_w_done, w_w_beat_end;

    // Read side
    logic [1:0]                 r_r_state, w_r_next;
    logic [AXI_ID_WIDTH-1:0]    r_ar_id;
    logic [3:0]                 r_ar_cache;
    logic [2:0]                 r_ar_prot;
    logic [7:0]                 r_r_cnt;
    logic                       r_arready, r_rvalid, r_rlast;
    logic [AXI_DATA_WIDTH-1:0]  r_rdata;
    logic [1:0]                 r_rresp;
    logic [AXI_ADDR_WIDTH-1:0]  w_r_addr;
    logic [2:0]                 w_r_size;
    logic                       w_r_legal, w_r_decerr;
    logic                       w_ar_hs, w_r_hs, w_r_skip, w_r_req, w_r_done, w_r_beat_end;

    // Arbiter / other port
    logic                       r_sel, r_owner_w, r_prio_w;
    logic                       r_o_write;
    logic [AXI_ADDR_WIDTH-1:0]  r_o_addr;
    logic [2:0]                 r_o_size;
    logic [3:0]                 r_o_cache;
    logic [2:0]                 r_o_prot;
    logic [AXI_WSTRB_WIDTH-1:0] r_o_strb;
    logic [AXI_DATA_WIDTH-1:0]  r_o_wdata;
    logic                       w_grant_w;

    axi_burst_addr_gen #(
        .ADDR_W(AXI_ADDR_WIDTH), .MAX_SIZE(MAX_SIZE), .ADDR_LO(ADDR_LO), .ADDR_HI(ADDR_HI)
    ) u_w_gen (
        .i_clk(axi_clk_in), .i_rst_n(axi_rstn_in), .i_start(w_aw_hs), .i_step(w_w_beat_end),
        .i_addr(axi_awaddr_in), .i_size(axi_awsize_in), .i_len(axi_awlen_in),
        .i_burst(axi_awburst_in), .o_addr(w_w_addr), .o_size(w_w_size),
        .o_legal(w_w_legal), .o_decerr(w_w_decerr)
    );

    axi_burst_addr_gen #(
        .ADDR_W(AXI_ADDR_WIDTH), .MAX_SIZE(MAX_SIZE), .ADDR_LO(ADDR_LO), .ADDR_HI(ADDR_HI)
    ) u_r_gen (
        .i_clk(axi_clk_in), .i_rst_n(axi_rstn_in), .i_start(w_ar_hs), .i_step(w_r_hs),
        .i_addr(axi_araddr_in), .i_size(axi_arsize_in), .i_len(axi_arlen_in),
        .i_burst(axi_arburst_in), .o_addr(w_r_addr), .o_size(w_r_size),
        .o_legal(w_r_legal), .o_decerr(w_r_decerr)
    );

    // Handshakes, per-beat requests and write next-state.
    always_comb begin
        w_aw_hs      = axi_awvalid_in & r_awready;
        w_w_hs       = axi_wvalid_in & r_wready;
        w_w_skip     = ~w_w_legal | w_w_decerr;
        w_w_req      = (r_w_state == W_ACC) & ~w_w_skip;
        w_w_done     = r_sel & r_owner_w & other_ready_in;
        w_w_beat_end = (r_w_state == W_ACC) & (w_w_skip | w_w_done);
        w_w_next     = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_aw_hs)       w_w_next = W_DATA;
            W_DATA:  if (w_w_hs)        w_w_next = W_ACC;
            W_ACC:   if (w_w_beat_end)  w_w_next = (r_w_cnt == 8'd0) ? W_RESP : W_DATA;
            W_RESP:  if (axi_bready_in) w_w_next = W_IDLE;
            default:                    w_w_next = W_IDLE;
        endcase
    end

    // Read handshakes, request and next-state.
    always_comb begin
        w_ar_hs      = axi_arvalid_in & r_arready;
        w_r_hs       = r_rvalid & axi_rready_in;
        w_r_skip     = ~w_r_legal | w_r_decerr;
        w_r_req      = (r_r_state == R_ACC) & ~w_r_skip;
        w_r_done     = r_sel & ~r_owner_w & other_ready_in;
        w_r_beat_end = (r_r_state == R_ACC) & (w_r_skip | w_r_done);
        w_grant_w    = w_w_req & (~w_r_req | r_prio_w);
        w_r_next     = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs)      w_r_next = R_ACC;
            R_ACC:   if (w_r_beat_end) w_r_next = R_DATA;
            R_DATA:  if (w_r_hs)       w_r_next = (r_r_cnt == 8'd0) ? R_IDLE : R_ACC;
            default:                   w_r_next = R_IDLE;
        endcase
    end

    // Write FSM state, channel outputs and burst bookkeeping.
    always_ff @(posedge axi_clk_in or negedge axi_rstn_in) begin
        if (!axi_rstn_in) begin
            r_w_state  <= W_IDLE;
            r_awready  <= 1'b1;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_aw_id    <= '0;
            r_aw_cache <= '0;
            r_aw_prot  <= '0;
            r_w_cnt    <= '0;
            r_w_err    <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else begin
            r_w_state <= w_w_next;
            r_awready <= (w_w_next == W_IDLE);
            r_wready  <= (w_w_next == W_DATA);
            r_bvalid  <= (w_w_next == W_RESP);
            if (w_aw_hs) begin
                r_aw_id    <= axi_awid_in;
                r_aw_cache <= axi_awcache_in;
                r_aw_prot  <= axi_awprot_in;
                r_w_cnt    <= axi_awlen_in;
                r_w_err    <= 1'b0;
            end
            if (w_w_hs) begin
                r_wdata <= axi_wdata_in;
                r_wstrb <= axi_wstrb_in;
                if (axi_wlast_in != (r_w_cnt == 8'd0)) r_w_err <= 1'b1;
            end
            if (w_w_done && other_error_in) r_w_err <= 1'b1;
            if (w_w_beat_end && r_w_cnt != 8'd0) r_w_cnt <= r_w_cnt - 8'd1;
            if (w_w_beat_end && r_w_cnt == 8'd0) begin
                if (w_w_decerr)
                    r_bresp <= RESP_DECERR;
                else if (!w_w_legal || r_w_err || (w_w_done && other_error_in))
                    r_bresp <= RESP_SLVERR;
                else
                    r_bresp <= RESP_OKAY;
            end
        end
    end

    // Read FSM state, R channel outputs and beat counter.
    always_ff @(posedge axi_clk_in or negedge axi_rstn_in) begin
        if (!axi_rstn_in) begin
            r_r_state  <= R_IDLE;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_ar_id    <= '0;
            r_ar_cache <= '0;
            r_ar_prot  <= '0;
            r_r_cnt    <= '0;
        end else begin
            r_r_state <= w_r_next;
            r_arready <= (w_r_next == R_IDLE);
            r_rvalid  <= (w_r_next == R_DATA);
            if (w_ar_hs) begin
                r_ar_id    <= axi_arid_in;
                r_ar_cache <= axi_arcache_in;
                r_ar_prot  <= axi_arprot_in;
                r_r_cnt    <= axi_arlen_in;
            end
            if (w_r_beat_end) begin
                r_rlast <= (r_r_cnt == 8'd0);
                r_rdata <= w_r_skip ? '0 : other_rdata_in;
                if (w_r_skip)
                    r_rresp <= w_r_decerr ? RESP_DECERR : RESP_SLVERR;
                else
                    r_rresp <= other_error_in ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_r_hs && r_r_cnt != 8'd0) r_r_cnt <= r_r_cnt - 8'd1;
        end
    end

    // Round-robin arbiter; payload frozen while sel is up, sel drops after acceptance.
    always_ff @(posedge axi_clk_in or negedge axi_rstn_in) begin
        if (!axi_rstn_in) begin
            r_sel     <= 1'b0;
            r_owner_w <= 1'b0;
            r_prio_w  <= 1'b1;
            r_o_write <= 1'b0;
            r_o_addr  <= '0;
            r_o_size  <= '0;
            r_o_cache <= '0;
            r_o_prot  <= '0;
            r_o_strb  <= '0;
            r_o_wdata <= '0;
        end else if (!r_sel) begin
            if (w_w_req || w_r_req) begin
                r_sel     <= 1'b1;
                r_owner_w <= w_grant_w;
                r_o_write <= w_grant_w;
                r_o_addr  <= w_grant_w ? w_w_addr   : w_r_addr;
                r_o_size  <= w_grant_w ? w_w_size   : w_r_size;
                r_o_cache <= w_grant_w ? r_aw_cache : r_ar_cache;
                r_o_prot  <= w_grant_w ? r_aw_prot  : r_ar_prot;
                r_o_strb  <= w_grant_w ? r_wstrb    : '0;
                r_o_wdata <= w_grant_w ? r_wdata    : '0;
            end
        end else if (other_ready_in) begin
            r_sel    <= 1'b0;
            r_prio_w <= ~r_prio_w;
        end
    end

    assign axi_awready_out = r_awready;
    assign axi_wready_out  = r_wready;
    assign axi_bvalid_out  = r_bvalid;
    assign axi_bresp_out   = r_bresp;
    assign axi_bid_out     = r_aw_id;
    assign axi_arready_out = r_arready;
    assign axi_rvalid_out  = r_rvalid;
    assign axi_rlast_out   = r_rlast;
    assign axi_rdata_out   = r_rdata;
    assign axi_rresp_out   = r_rresp;
    assign axi_rid_out     = r_ar_id;
    assign other_sel_out   = r_sel;
    assign other_write_out = r_o_write;
    assign other_addr_out  = r_o_addr;
    assign other_size_out  = r_o_size;
    assign other_cache_out = r_o_cache;
    assign other_prot_out  = r_o_prot;
    assign other_strb_out  = r_o_strb;
    assign other_wdata_out = r_o_wdata;

endmodule

// File: tb/tb_axi_slave_bridge.sv
// Directed self-checking bench for axi_slave_bridge (default build, 32-bit bus).
module tb_axi_slave_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, araddr, wdata;
    logic [1:0]  awburst, arburst;
    logic [3:0]  awcache, arcache, awid, arid, wstrb;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awprot, arprot, awsize, arsize;
    logic        awvalid, wlast, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rlast, rvalid;
    logic [3:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        o_sel, o_write;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [2:0]  o_size, o_prot;
    logic [3:0]  o_cache, o_strb;
    logic        o_ready, o_error;
    logic        err_en;
    logic [31:0] err_addr;

    int checks = 0;
    int errors = 0;

    // other-port access log
    int          acc_n = 0;
    logic        acc_wr   [0:15];
    logic [31:0] acc_addr [0:15];
    logic [31:0] acc_data [0:15];
    logic [3:0]  acc_strb [0:15];
    logic [2:0]  acc_size [0:15];
    logic [3:0]  acc_cache[0:15];
    logic [2:0]  acc_prot [0:15];

    // results captured by the drivers
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic [31:0] rd_data[0:15];
    logic [1:0]  rd_resp[0:15];
    logic        rd_last[0:15];
    logic [3:0]  rd_id;
    logic        rd_stable;

    always #5 clk = ~clk;

    assign o_rdata = o_addr ^ 32'h5A5A_0000;
    assign o_error = err_en && o_sel && (o_addr == err_addr);

    axi_slave_bridge dut (
        .axi_clk_in(clk), .axi_rstn_in(rst_n),
        .axi_awaddr_in(awaddr), .axi_awburst_in(awburst), .axi_awcache_in(awcache),
        .axi_awid_in(awid), .axi_awlen_in(awlen), .axi_awprot_in(awprot),
        .axi_awsize_in(awsize), .axi_awvalid_in(awvalid), .axi_awready_out(awready),
        .axi_wdata_in(wdata), .axi_wstrb_in(wstrb), .axi_wlast_in(wlast),
        .axi_wvalid_in(wvalid), .axi_wready_out(wready),
        .axi_bid_out(bid), .axi_bresp_out(bresp), .axi_bvalid_out(bvalid), .axi_bready_in(bready),
        .axi_araddr_in(araddr), .axi_arburst_in(arburst), .axi_arcache_in(arcache),
        .axi_arid_in(arid), .axi_arlen_in(arlen), .axi_arprot_in(arprot),
        .axi_arsize_in(arsize), .axi_arvalid_in(arvalid), .axi_arready_out(arready),
        .axi_rid_out(rid), .axi_rdata_out(rdata), .axi_rresp_out(rresp),
        .axi_rlast_out(rlast), .axi_rvalid_out(rvalid), .axi_rready_in(rready),
        .other_sel_out(o_sel), .other_write_out(o_write), .other_addr_out(o_addr),
        .other_size_out(o_size), .other_cache_out(o_cache), .other_prot_out(o_prot),
        .other_strb_out(o_strb), .other_wdata_out(o_wdata), .other_rdata_in(o_rdata),
        .other_ready_in(o_ready), .other_error_in(o_error)
    );

    // Log each accepted other-port access mid-cycle.
    always @(negedge clk) begin
        if (rst_n && o_sel && o_ready && acc_n < 16) begin
            acc_wr[acc_n]    = o_write;
            acc_addr[acc_n]  = o_addr;
            acc_data[acc_n]  = o_wdata;
            acc_strb[acc_n]  = o_strb;
            acc_size[acc_n]  = o_size;
            acc_cache[acc_n] = o_cache;
            acc_prot[acc_n]  = o_prot;
            acc_n = acc_n + 1;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input logic [31:0] dbase);
        int n;
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id;
        awcache = 4'h3; awprot = 3'h2; awvalid = 1'b1;
        n = 0; @(negedge clk);
        while (!awready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin checks++; errors++; $display("FAIL aw_timeout awready=%0b want 1", awready); end
        @(posedge clk); #1 awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = dbase + 32'(b); wstrb = 4'hF; wlast = (b == int'(len)); wvalid = 1'b1;
            n = 0; @(negedge clk);
            while (!wready && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) begin checks++; errors++; $display("FAIL w_timeout wready=%0b want 1", wready); end
            @(posedge clk); #1 wvalid = 1'b0;
        end
        n = 0; @(negedge clk);
        while (!bvalid && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin checks++; errors++; $display("FAIL b_timeout bvalid=%0b want 1", bvalid); end
        b_resp = bresp; b_id = bid; bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int stall_beat);
        int n;
        logic [31:0] sd; logic [1:0] sr; logic sl;
        araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id;
        arcache = 4'h5; arprot = 3'h1; arvalid = 1'b1;
        n = 0; @(negedge clk);
        while (!arready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin checks++; errors++; $display("FAIL ar_timeout arready=%0b want 1", arready); end
        @(posedge clk); #1 arvalid = 1'b0;
        rd_stable = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0; @(negedge clk);
            while (!rvalid && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) begin checks++; errors++; $display("FAIL r_timeout rvalid=%0b want 1", rvalid); end
            if (b == stall_beat) begin
                sd = rdata; sr = rresp; sl = rlast;
                repeat (3) begin
                    @(negedge clk);
                    if (rdata !== sd || rresp !== sr || rlast !== sl || !rvalid) rd_stable = 1'b0;
                end
            end
            rd_data[b] = rdata; rd_resp[b] = rresp; rd_last[b] = rlast; rd_id = rid;
            rready = 1'b1;
            @(posedge clk); #1 rready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks += 6;
        if (awready !== 1'b1) begin errors++; $display("FAIL reset_awready got=%0b want=1", awready); end
        if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready got=%0b want=1", arready); end
        if (wready  !== 1'b0) begin errors++; $display("FAIL reset_wready got=%0b want=0", wready); end
        if (bvalid  !== 1'b0) begin errors++; $display("FAIL reset_bvalid got=%0b want=0", bvalid); end
        if (rvalid  !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%0b want=0", rvalid); end
        if (o_sel   !== 1'b0) begin errors++; $display("FAIL reset_sel got=%0b want=0", o_sel); end
        do_reset();
    endtask

    task automatic test_incr_write();
        acc_n = 0;
        do_write(32'h100, 8'd3, 3'd2, 2'd1, 4'd5, 32'hA0);
        checks++;
        if (acc_n !== 4) begin errors++; $display("FAIL incr_w_count got=%0d want=4", acc_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_wr[i] !== 1'b1 || acc_addr[i] !== 32'h100 + 32'(4*i) || acc_data[i] !== 32'hA0 + 32'(i)
                || acc_strb[i] !== 4'hF || acc_size[i] !== 3'd2) begin
                errors++;
                $display("FAIL incr_w_beat%0d got wr=%0b addr=%h data=%h strb=%h size=%0d want wr=1 addr=%h data=%h strb=f size=2",
                         i, acc_wr[i], acc_addr[i], acc_data[i], acc_strb[i], acc_size[i],
                         32'h100 + 32'(4*i), 32'hA0 + 32'(i));
            end
        end
        checks += 3;
        if (acc_cache[0] !== 4'h3 || acc_prot[0] !== 3'h2) begin
            errors++; $display("FAIL incr_w_attr got cache=%h prot=%h want cache=3 prot=2", acc_cache[0], acc_prot[0]);
        end
        if (b_resp !== 2'd0) begin errors++; $display("FAIL incr_w_bresp got=%0d want=0", b_resp); end
        if (b_id !== 4'd5) begin errors++; $display("FAIL incr_w_bid got=%0d want=5", b_id); end
    endtask

    task automatic test_wrap_read();
        logic [31:0] exp_a [0:3];
        exp_a[0] = 32'h38; exp_a[1] = 32'h3C; exp_a[2] = 32'h30; exp_a[3] = 32'h34;
        acc_n = 0;
        do_read(32'h38, 8'd3, 3'd2, 2'd2, 4'd3, 1);
        checks++;
        if (acc_n !== 4) begin errors++; $display("FAIL wrap_r_count got=%0d want=4", acc_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_wr[i] !== 1'b0 || acc_addr[i] !== exp_a[i] || rd_data[i] !== (exp_a[i] ^ 32'h5A5A_0000)
                || rd_resp[i] !== 2'd0 || rd_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL wrap_r_beat%0d got addr=%h data=%h resp=%0d last=%0b want addr=%h data=%h resp=0 last=%0b",
                         i, acc_addr[i], rd_data[i], rd_resp[i], rd_last[i], exp_a[i],
                         exp_a[i] ^ 32'h5A5A_0000, (i == 3));
            end
        end
        checks += 2;
        if (rd_id !== 4'd3) begin errors++; $display("FAIL wrap_r_rid got=%0d want=3", rd_id); end
        if (rd_stable !== 1'b1) begin errors++; $display("FAIL wrap_r_stall_stable got=%0b want=1", rd_stable); end
    endtask

    task automatic test_concurrent();
        logic        exp_w [0:3];
        logic [31:0] exp_a [0:3];
        exp_w[0] = 1; exp_w[1] = 0; exp_w[2] = 1; exp_w[3] = 0;
        exp_a[0] = 32'h200; exp_a[1] = 32'h300; exp_a[2] = 32'h204; exp_a[3] = 32'h304;
        do_reset();
        acc_n = 0;
        fork
            do_write(32'h200, 8'd1, 3'd2, 2'd1, 4'd1, 32'hB0);
            begin @(posedge clk); #1 do_read(32'h300, 8'd1, 3'd2, 2'd1, 4'd2, -1); end
        join
        checks++;
        if (acc_n !== 4) begin errors++; $display("FAIL conc_count got=%0d want=4", acc_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_wr[i] !== exp_w[i] || acc_addr[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL conc_order%0d got wr=%0b addr=%h want wr=%0b addr=%h",
                         i, acc_wr[i], acc_addr[i], exp_w[i], exp_a[i]);
            end
        end
        checks += 2;
        if (b_resp !== 2'd0) begin errors++; $display("FAIL conc_bresp got=%0d want=0", b_resp); end
        if (rd_data[1] !== 32'h5A5A_0304 || rd_last[1] !== 1'b1) begin
            errors++; $display("FAIL conc_rbeat1 got data=%h last=%0b want data=5a5a0304 last=1", rd_data[1], rd_last[1]);
        end
    endtask

    task automatic test_error();
        err_en = 1'b1; err_addr = 32'h404;
        acc_n = 0;
        do_write(32'h400, 8'd3, 3'd2, 2'd1, 4'd9, 32'h10);
        checks += 2;
        if (acc_n !== 4) begin errors++; $display("FAIL err_w_count got=%0d want=4", acc_n); end
        if (b_resp !== 2'd2) begin errors++; $display("FAIL err_w_bresp got=%0d want=2", b_resp); end
        acc_n = 0;
        do_read(32'h400, 8'd3, 3'd2, 2'd1, 4'd9, -1);
        checks++;
        if (acc_n !== 4) begin errors++; $display("FAIL err_r_count got=%0d want=4", acc_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_resp[i] !== ((i == 1) ? 2'd2 : 2'd0)) begin
                errors++; $display("FAIL err_r_resp%0d got=%0d want=%0d", i, rd_resp[i], (i == 1) ? 2 : 0);
            end
        end
        err_en = 1'b0;
    endtask

    task automatic test_illegal();
        acc_n = 0;
        do_write(32'h800, 8'd1, 3'd2, 2'd3, 4'd4, 32'h0);
        checks += 2;
        if (acc_n !== 0) begin errors++; $display("FAIL ill_w_count got=%0d want=0", acc_n); end
        if (b_resp !== 2'd2) begin errors++; $display("FAIL ill_w_bresp got=%0d want=2", b_resp); end
        do_read(32'h40, 8'd2, 3'd2, 2'd2, 4'd6, -1);
        checks++;
        if (acc_n !== 0) begin errors++; $display("FAIL ill_r_count got=%0d want=0", acc_n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_resp[i] !== 2'd2 || rd_last[i] !== (i == 2)) begin
                errors++; $display("FAIL ill_r_beat%0d got resp=%0d last=%0b want resp=2 last=%0b",
                                   i, rd_resp[i], rd_last[i], (i == 2));
            end
        end
        @(negedge clk);
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            errors++; $display("FAIL ill_idle got awready=%0b arready=%0b want 1 1", awready, arready);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        o_ready = 1'b0;
        awaddr = 32'h500; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1; awid = 4'd2; awvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0;
        wdata = 32'h55; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        n = 0; @(negedge clk);
        while (!wready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 wvalid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_sel !== 1'b1) begin errors++; $display("FAIL mid_sel_before got=%0b want=1", o_sel); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o_sel !== 1'b0 || awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin
            errors++; $display("FAIL mid_async_reset got sel=%0b awready=%0b wready=%0b bvalid=%0b want 0 1 0 0",
                               o_sel, awready, wready, bvalid);
        end
        o_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        acc_n = 0;
        do_write(32'h600, 8'd0, 3'd2, 2'd1, 4'd7, 32'hC0);
        checks += 2;
        if (acc_n !== 1 || acc_addr[0] !== 32'h600 || acc_data[0] !== 32'hC0) begin
            errors++; $display("FAIL mid_new_write got n=%0d addr=%h data=%h want n=1 addr=600 data=c0",
                               acc_n, acc_addr[0], acc_data[0]);
        end
        if (b_resp !== 2'd0 || b_id !== 4'd7) begin
            errors++; $display("FAIL mid_new_bresp got resp=%0d id=%0d want resp=0 id=7", b_resp, b_id);
        end
    endtask

    initial begin
        awaddr = 0; awburst = 0; awcache = 0; awid = 0; awlen = 0; awprot = 0; awsize = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        araddr = 0; arburst = 0; arcache = 0; arid = 0; arlen = 0; arprot = 0; arsize = 0; arvalid = 0;
        rready = 0; o_ready = 1'b1; err_en = 1'b0; err_addr = 0; rst_n = 1'b0;
        test_reset();
        test_incr_write();
        test_wrap_read();
        test_concurrent();
        test_error();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
